// File: rtl/fg_prog_pkg.sv
// Shared types and constants for the floating-gate programming sequencer.
package fg_prog_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        MEAS    = 3'd3,
        COMPARE = 3'd4,
        PULSE   = 3'd5,
        RESP    = 3'd6
    } state_e;

    localparam int unsigned PULSE_CNT_W = 8;

    localparam logic [1:0] STAT_OK        = 2'd0;
    localparam logic [1:0] STAT_TIMEOUT   = 2'd1;
    localparam logic [1:0] STAT_OVERSHOOT = 2'd2;
    localparam logic [1:0] STAT_BAD       = 2'd3;

    typedef struct packed {
        logic [1:0]             status;
        logic [PULSE_CNT_W-1:0] pulses;
    } rsp_t;

    // States during which a row is selected and the island is in program mode
    function automatic logic is_active(input state_e s);
        return (s == SELECT) || (s == SETTLE) || (s == MEAS) || (s == COMPARE) || (s == PULSE);
    endfunction

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter; done_c is high once the loaded count has run down to zero.
module fg_prog_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Closed-loop measure/inject programming sequencer for one floating-gate row per command.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 10,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned MEAS_W     = 12,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned PULSE_CYC  = 64,
    parameter int unsigned MAX_PULSES = 255,
    parameter int unsigned TOL        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_row,
    input  logic [MEAS_W-1:0]      cmd_target,
    input  logic                   abort,
    output logic                   prog_en,
    output logic [ADDR_W-1:0]      dec_addr,
    output logic [NUM_ROWS-1:0]    drain_sel,
    output logic                   inj_pulse,
    output logic                   meas_req,
    input  logic                   meas_valid,
    input  logic [MEAS_W-1:0]      meas_code,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [PULSE_CNT_W-1:0] rsp_pulses
);

    localparam int unsigned TMR_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned CW      = MEAS_W + 1;

    state_e                 state, state_n;
    rsp_t                   rsp_q, rsp_n;
    logic [ADDR_W-1:0]      row_q, row_n;
    logic [MEAS_W-1:0]      target_q, meas_q;
    logic [PULSE_CNT_W-1:0] pulses_q;
    logic                   accept_c, bad_row_c;
    logic                   tmr_load_c, tmr_done_c;
    logic [TMR_W-1:0]       tmr_val_c;
    logic [CW-1:0]          lo_ext, hi_ext;
    logic [MEAS_W-1:0]      lo_c, hi_c;
    logic                   prog_en_n, inj_pulse_n, meas_req_n;
    logic [ADDR_W-1:0]      dec_addr_n;
    logic [NUM_ROWS-1:0]    drain_sel_n;

    assign accept_c  = cmd_valid && (state == IDLE);
    assign bad_row_c = (cmd_row >= ADDR_W'(NUM_ROWS));

    // Accept window with both edges clamped to the code range
    assign hi_ext = CW'(target_q) + CW'(TOL);
    assign lo_ext = CW'(target_q) - CW'(TOL);
    assign hi_c   = hi_ext[MEAS_W] ? '1 : hi_ext[MEAS_W-1:0];
    assign lo_c   = lo_ext[MEAS_W] ? '0 : lo_ext[MEAS_W-1:0];

    // SETTLE and PULSE share one timer, loaded on entry to either state
    assign tmr_load_c = ((state_n == SETTLE) && (state != SETTLE)) ||
                        ((state_n == PULSE)  && (state != PULSE));
    assign tmr_val_c  = (state_n == PULSE) ? TMR_W'(PULSE_CYC - 1) : TMR_W'(SETTLE_CYC - 1);

    fg_prog_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    // State register, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_q     <= '0;
            row_q     <= '0;
            target_q  <= '0;
            meas_q    <= '0;
            pulses_q  <= '0;
            cmd_ready <= 1'b1;
            prog_en   <= 1'b0;
            dec_addr  <= '0;
            drain_sel <= '0;
            inj_pulse <= 1'b0;
            meas_req  <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_q     <= rsp_n;
            row_q     <= row_n;
            if (accept_c) begin
                target_q <= cmd_target;
                pulses_q <= '0;
            end else if ((state_n == PULSE) && (state != PULSE) && (pulses_q != '1)) begin
                pulses_q <= pulses_q + PULSE_CNT_W'(1);
            end
            if ((state == MEAS) && meas_valid) begin
                meas_q <= meas_code;
            end
            cmd_ready <= (state_n == IDLE);
            prog_en   <= prog_en_n;
            dec_addr  <= dec_addr_n;
            drain_sel <= drain_sel_n;
            inj_pulse <= inj_pulse_n;
            meas_req  <= meas_req_n;
            rsp_valid <= (state_n == RESP);
        end
    end

    // Next-state and response payload
    always_comb begin
        state_n = state;
        rsp_n   = rsp_q;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (bad_row_c) begin
                        state_n = RESP;
                        rsp_n   = '{status: STAT_BAD, pulses: '0};
                    end else begin
                        state_n = SELECT;
                    end
                end
            end
            SELECT:  state_n = SETTLE;
            SETTLE:  if (tmr_done_c) state_n = MEAS;
            MEAS:    if (meas_valid) state_n = COMPARE;
            COMPARE: begin
                if ((meas_q >= lo_c) && (meas_q <= hi_c)) begin
                    state_n = RESP;
                    rsp_n   = '{status: STAT_OK, pulses: pulses_q};
                end else if (meas_q > hi_c) begin
                    state_n = RESP;
                    rsp_n   = '{status: STAT_OVERSHOOT, pulses: pulses_q};
                end else if (pulses_q == PULSE_CNT_W'(MAX_PULSES)) begin
                    state_n = RESP;
                    rsp_n   = '{status: STAT_TIMEOUT, pulses: pulses_q};
                end else begin
                    state_n = PULSE;
                end
            end
            PULSE:   if (tmr_done_c) state_n = SETTLE;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (is_active(state) && abort) begin
            state_n = RESP;
            rsp_n   = '{status: STAT_BAD, pulses: pulses_q};
        end
    end

    // Next values of the island-facing outputs, derived from the upcoming state
    always_comb begin
        row_n       = accept_c ? cmd_row : row_q;
        prog_en_n   = is_active(state_n);
        dec_addr_n  = prog_en_n ? row_n : '0;
        drain_sel_n = prog_en_n ? (NUM_ROWS'(1) << row_n) : '0;
        inj_pulse_n = (state_n == PULSE);
        meas_req_n  = (state_n == MEAS) && (state != MEAS);
    end

    assign rsp_status = rsp_q.status;
    assign rsp_pulses = rsp_q.pulses;

endmodule
